// File: rtl/gpin_pkg.sv
// Shared encodings for the GPIN sync/filter array: per-channel mode and filter FSM states.
package gpin_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS   = 2'b00,
    MODE_SYNC     = 2'b01,
    MODE_FILT     = 2'b10,
    MODE_FILT_INV = 2'b11
  } gpin_mode_t;

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_PEND_HI   = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_PEND_LO   = 2'b11
  } filt_state_t;

endpackage

// File: rtl/gpin_filter_ch.sv
// One GPIN channel: synchroniser, glitch filter, edge detect and output mode mux.
//
// state        | meaning
// ST_STABLE_LO | filtered value 0, sync input agrees
// ST_PEND_HI   | filtered value 0, counting consecutive high samples
// ST_STABLE_HI | filtered value 1, sync input agrees
// ST_PEND_LO   | filtered value 1, counting consecutive low samples
module gpin_filter_ch
  import gpin_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pad,
  input  gpin_mode_t        mode,
  input  logic [FILT_W-1:0] filt_len,
  output logic              inpad,
  output logic              rise,
  output logic              fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  filt_state_t            state_q, state_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic [FILT_W-1:0]      leff;
  logic                   leff_one;
  logic [FILT_W:0]        cnt_inc;
  logic                   cnt_done;
  logic                   filt_val;
  logic                   edge_src;
  logic                   prev_q;
  logic                   rise_i;
  logic                   fall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // A zero length is treated as one so a change is never blocked forever.
  assign leff     = (filt_len == '0) ? FILT_W'(1) : filt_len;
  assign leff_one = (leff == FILT_W'(1));
  assign cnt_inc  = {1'b0, cnt_q} + (FILT_W+1)'(1);
  assign cnt_done = (cnt_inc >= {1'b0, leff});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STABLE_LO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STABLE_LO: begin
        cnt_d = '0;
        if (sync_s) begin
          if (leff_one) begin
            state_d = ST_STABLE_HI;
          end else begin
            state_d = ST_PEND_HI;
            cnt_d   = FILT_W'(1);
          end
        end
      end
      ST_PEND_HI: begin
        if (!sync_s) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[FILT_W-1:0];
        end
      end
      ST_STABLE_HI: begin
        cnt_d = '0;
        if (!sync_s) begin
          if (leff_one) begin
            state_d = ST_STABLE_LO;
          end else begin
            state_d = ST_PEND_LO;
            cnt_d   = FILT_W'(1);
          end
        end
      end
      ST_PEND_LO: begin
        if (sync_s) begin
          state_d = ST_STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_done) begin
          state_d = ST_STABLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc[FILT_W-1:0];
        end
      end
      default: begin
        state_d = ST_STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign filt_val = (state_q == ST_STABLE_HI) || (state_q == ST_PEND_LO);

  // Bypass edges come from the synchronised value, never the raw pad.
  assign edge_src = ((mode == MODE_BYPASS) || (mode == MODE_SYNC)) ? sync_s : filt_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= edge_src;
    end
  end

  assign rise_i = edge_src & ~prev_q;
  assign fall_i = ~edge_src & prev_q;

  always_comb begin
    inpad = 1'b0;
    rise  = rise_i;
    fall  = fall_i;
    case (mode)
      MODE_BYPASS: inpad = pad;
      MODE_SYNC:   inpad = sync_s;
      MODE_FILT:   inpad = filt_val;
      MODE_FILT_INV: begin
        inpad = ~filt_val;
        rise  = fall_i;
        fall  = rise_i;
      end
      default: inpad = 1'b0;
    endcase
  end

endmodule

// File: rtl/gpin_sync_filter_array.sv
// Array of NUM_CH GPIN channels sharing one filter length; each channel has its own mode.
module gpin_sync_filter_array
  import gpin_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   gfpga_pad_GPIN_PAD,
  input  logic [2*NUM_CH-1:0] cfg_mode,
  input  logic [FILT_W-1:0]   cfg_filt_len,
  output logic [NUM_CH-1:0]   iopad_inpad,
  output logic [NUM_CH-1:0]   iopad_rise,
  output logic [NUM_CH-1:0]   iopad_fall
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    gpin_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .pad      (gfpga_pad_GPIN_PAD[i]),
      .mode     (gpin_mode_t'(cfg_mode[2*i +: 2])),
      .filt_len (cfg_filt_len),
      .inpad    (iopad_inpad[i]),
      .rise     (iopad_rise[i]),
      .fall     (iopad_fall[i])
    );
  end

endmodule

// File: tb/tb_gpin_sync_filter_array.sv
// Directed bench for gpin_sync_filter_array with hand-computed expectations (SYNC_STAGES=2).
module tb_gpin_sync_filter_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pad;
  logic [7:0] cfg_mode;
  logic [3:0] cfg_filt_len;
  logic [3:0] inpad;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] acc_in;
  logic [3:0] acc_edge;

  gpin_sync_filter_array #(
    .NUM_CH      (4),
    .SYNC_STAGES (2),
    .FILT_W      (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .gfpga_pad_GPIN_PAD (pad),
    .cfg_mode           (cfg_mode),
    .cfg_filt_len       (cfg_filt_len),
    .iopad_inpad        (inpad),
    .iopad_rise         (rise),
    .iopad_fall         (fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset(input logic [7:0] mode, input logic [3:0] len);
    rst_n        = 1'b0;
    pad          = 4'h0;
    cfg_mode     = mode;
    cfg_filt_len = len;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
  endtask

  initial begin
    rst_n = 1'b0; pad = '0; cfg_mode = '0; cfg_filt_len = '0;

    // mode 01 everywhere: sync-only, 2-cycle latency, one-cycle rise
    cfg_mode = 8'h55; cfg_filt_len = 4'd4;
    ticks(2);
    chk("rst_inpad_sync", inpad, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    rst_n = 1'b1;
    ticks(10);
    pad[0] = 1'b1;
    tick();
    chk("sync_lat1", inpad[0], 1'b0);
    chk("sync_rise_early", rise[0], 1'b0);
    tick();
    chk("sync_lat2", inpad[0], 1'b1);
    chk("sync_rise", rise[0], 1'b1);
    tick();
    chk("sync_rise_one", rise[0], 1'b0);
    pad[0] = 1'b0;
    ticks(2);
    chk("sync_fall_val", inpad[0], 1'b0);
    chk("sync_fall", fall[0], 1'b1);
    tick();
    chk("sync_fall_one", fall[0], 1'b0);

    // mode 10, L=4: 3-cycle glitch suppressed, sustained high at +6
    do_reset(8'h02, 4'd4);
    acc_in = '0; acc_edge = '0;
    pad[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin tick(); acc_in |= inpad; acc_edge |= rise | fall; end
    pad[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); acc_in |= inpad; acc_edge |= rise | fall; end
    chk("glitch_inpad", acc_in[0], 1'b0);
    chk("glitch_edges", acc_edge[0], 1'b0);
    pad[0] = 1'b1;
    ticks(5);
    chk("filt_lat5", inpad[0], 1'b0);
    tick();
    chk("filt_lat6", inpad[0], 1'b1);
    chk("filt_rise", rise[0], 1'b1);
    tick();
    chk("filt_rise_one", rise[0], 1'b0);

    // mode 11, L=1: inverted, high at reset, fall pulse on pad rise
    rst_n = 1'b0; pad = '0; cfg_mode = 8'h03; cfg_filt_len = 4'd1;
    tick();
    chk("inv_rst_inpad", inpad[0], 1'b1);
    rst_n = 1'b1;
    ticks(3);
    pad[0] = 1'b1;
    ticks(2);
    chk("inv_lat2", inpad[0], 1'b1);
    tick();
    chk("inv_lat3", inpad[0], 1'b0);
    chk("inv_fall", fall[0], 1'b1);
    chk("inv_no_rise", rise[0], 1'b0);
    tick();
    chk("inv_fall_one", fall[0], 1'b0);

    // mode 00: raw pad during reset and same-cycle, edges from sync path
    rst_n = 1'b0; cfg_mode = 8'h00; cfg_filt_len = 4'd4; pad = 4'b1010;
    #1;
    chk("byp_rst_raw", inpad, 4'b1010);
    pad = 4'h0;
    tick();
    rst_n = 1'b1;
    ticks(3);
    pad[1] = 1'b1;
    #1;
    chk("byp_same_cycle", inpad[1], 1'b1);
    chk("byp_no_rise0", rise[1], 1'b0);
    tick();
    chk("byp_no_rise1", rise[1], 1'b0);
    tick();
    chk("byp_rise2", rise[1], 1'b1);
    tick();
    chk("byp_rise_one", rise[1], 1'b0);

    // L=0 behaves as L=1
    do_reset(8'h02, 4'd0);
    pad[0] = 1'b1;
    ticks(2);
    chk("l0_lat2", inpad[0], 1'b0);
    tick();
    chk("l0_lat3", inpad[0], 1'b1);
    chk("l0_rise", rise[0], 1'b1);

    // L lowered 8->2 while pending with cnt=5
    do_reset(8'h02, 4'd8);
    pad[0] = 1'b1;
    ticks(7);
    chk("lchg_pend", inpad[0], 1'b0);
    cfg_filt_len = 4'd2;
    tick();
    chk("lchg_accept", inpad[0], 1'b1);
    chk("lchg_rise", rise[0], 1'b1);

    // reset mid-PEND_HI on all channels, modes {11,10,01,00}
    do_reset(8'hE4, 4'd8);
    pad = 4'hF;
    ticks(4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_inpad", inpad, 4'b1001);
    chk("mid_rst_rise", rise, 4'h0);
    chk("mid_rst_fall", fall, 4'h0);
    pad = 4'h0;
    tick();
    rst_n = 1'b1;
    acc_edge = '0;
    for (int k = 0; k < 10; k++) begin tick(); acc_edge |= rise | fall; end
    chk("post_rst_edges", acc_edge, 4'h0);
    chk("post_rst_inpad", inpad, 4'b1000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/gpin_sync_filter_array.md
Name: gpin_sync_filter_array

Overview:
- Parametrised successor of the single-bit GPIN input pad primitive.
- Takes NUM_CH general-purpose input pads and delivers each to the fabric in one of four per-channel modes: raw bypass, synchronised, glitch-filtered, or filtered-and-inverted.
- Each channel also produces single-cycle rise/fall pulses for fabric logic.
- Sits in the IO logical tile in place of per-pin GPIN instances; mode and filter length come from configuration bits.

Parameters:
- NUM_CH, 4, number of pad channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILT_W, 4, width of the filter counter and of cfg_filt_len.

Ports:
- clk  input  1  fabric clock.
- rst_n  input  1  reset, asynchronous, active-low.
- gfpga_pad_GPIN_PAD  input  NUM_CH  raw pad inputs, asynchronous to clk.
- cfg_mode  input  2*NUM_CH  per-channel mode, bits [2i+1:2i]: 00 bypass, 01 sync, 10 filtered, 11 filtered+inverted; quasi-static.
- cfg_filt_len  input  FILT_W  shared filter length L, in clk cycles; quasi-static.
- iopad_inpad  output  NUM_CH  per-channel selected pad value to fabric.
- iopad_rise  output  NUM_CH  one-cycle pulse on a rising edge of the presented value.
- iopad_fall  output  NUM_CH  one-cycle pulse on a falling edge of the presented value.

Behaviour:
- Reset (async assert, sync-safe deassert not required inside block): all synchroniser flops 0; filter state STABLE_LO; counters 0; edge prev-regs 0.
- Outputs during reset:
  - iopad_rise and iopad_fall are 0.
  - iopad_inpad is 0 for modes 01/10, 1 for mode 11, and the raw pad value for mode 00.
- Synchroniser: SYNC_STAGES-flop chain per channel; sync value s lags the pad by SYNC_STAGES cycles.
- Filter FSM per channel, with states STABLE_LO, PEND_HI, STABLE_HI, PEND_LO; let Leff = max(L,1).
  - STABLE_x, s==x: stay, cnt=0.
  - STABLE_x, s!=x: if Leff==1, go to STABLE_!x. Otherwise go to PEND_!x with cnt=1.
  - PEND_!x, s==x (bounce): return to STABLE_x, cnt=0.
  - PEND_!x, s!=x: if cnt+1 >= Leff, go to STABLE_!x with cnt=0. Otherwise cnt++.
  - Filtered value f = 1 in STABLE_HI/PEND_LO, 0 otherwise.
  - A change is accepted after exactly Leff consecutive differing sync samples.
  - Latency from pad to f is SYNC_STAGES+Leff cycles.
  - Pulses shorter than Leff sync samples are suppressed.
- L changed mid-pend: the >= compare is used, so if cnt already >= new Leff, the transition occurs on the next differing sample. The counter never wraps, since it saturates by construction (cnt < Leff <= 2^FILT_W-1).
- Output mux (combinational from registers, except mode 00):
  - 00 gives the raw pad, 0 cycles latency.
  - 01 gives s.
  - 10 gives f.
  - 11 gives ~f.
- Edge detect: source e = s for modes 00/01, e = f for modes 10/11. Registered prev p <= e.
  - rise_i = e & ~p; fall_i = ~e & p.
  - Mode 11 swaps them: iopad_rise = fall_i, iopad_fall = rise_i, so pulses match the inverted value.
  - Mode 00 edges come from s, never the raw pad, and therefore lag iopad_inpad by SYNC_STAGES cycles.
  - Because p resets to 0, no edge pulse occurs on reset release.
- Mode change mid-operation: at most one spurious edge pulse on that channel; the filter keeps running in all modes.
- Channels are fully independent apart from the shared cfg_filt_len.

Decomposition:
- Shared package/header gpin_pkg holds:
  - mode encodings MODE_BYPASS=2'b00, MODE_SYNC=2'b01, MODE_FILT=2'b10, MODE_FILT_INV=2'b11;
  - FSM state encodings for the four filter states.
- One sub-module, gpin_filter_ch: synchroniser, filter FSM, edge detect and mux for a single channel. The top generates NUM_CH instances.

Test Plan:
- Reset then mode 01, pad0 0->1 at cycle 10 -> iopad_inpad[0]=1 at cycle 12 (SYNC_STAGES=2); iopad_rise[0]=1 for exactly cycle 12.
- Mode 10, L=4, 3-cycle high glitch -> iopad_inpad stays 0, no pulses. Sustained high -> output 1 at pad edge +6 cycles, one rise pulse.
- Mode 11, L=1 -> iopad_inpad=1 at reset. Pad high -> output 0 after 3 cycles, with iopad_fall pulse and no rise pulse.
- Mode 00 -> iopad_inpad follows pad in the same cycle; iopad_rise pulse 2 cycles after the edge.
- L=0 behaves identically to L=1. L lowered from 8 to 2 while the FSM is pending with cnt=5 -> transition on the next differing sample.
- rst_n asserted mid-PEND_HI on all 4 channels with mixed modes -> outputs immediately at reset values; after release, no pulses until a pad changes.
